// File: rtl/bcd_countdown.sv
// Four-digit BCD millisecond down-counter with built-in prescaler, IDLE/RUN control and a one-cycle done pulse.
// Define BCD_COUNTDOWN_AUTORELOAD_EN to reload the last loaded value on expiry, which turns it into a periodic timer.
module bcd_countdown #(
    parameter int TICK_DIV = 50000,
    parameter int PRE_W    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] LD0,
    input  logic [3:0] LD1,
    input  logic [3:0] LD2,
    input  logic [3:0] LD3,
    input  logic       start,
    input  logic       abort,
    output logic [3:0] BCD0,
    output logic [3:0] BCD1,
    output logic [3:0] BCD2,
    output logic [3:0] BCD3,
    output logic       running,
    output logic       done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_cnt;
    logic [15:0]      w_cnt_nxt;
    logic [PRE_W-1:0] r_pre;
    logic [PRE_W-1:0] w_pre_nxt;
    logic             r_done;
    logic             w_done_nxt;

    logic [15:0]      w_ld;
    logic [15:0]      w_dec;
    logic             w_borrow;
    logic             w_ld_zero;
    logic             w_cnt_zero;
    logic             w_dec_zero;
    logic             w_tick;

`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
    logic [15:0]      r_shadow;
`endif

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign w_ld       = {clamp_digit(LD3), clamp_digit(LD2), clamp_digit(LD1), clamp_digit(LD0)};
    assign w_ld_zero  = (w_ld == 16'h0000);
    assign w_cnt_zero = (r_cnt == 16'h0000);
    assign w_dec_zero = (w_dec == 16'h0000);
    assign w_tick     = (r_state == ST_RUN) && (r_pre == PRE_MAX);

    // Borrow ripples from BCD0 upward; RUN never holds 0000, so no underflow path is reached.
    always_comb begin
        w_dec    = r_cnt;
        w_borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_borrow) begin
                if (r_cnt[4*i +: 4] == 4'd0) begin
                    w_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_dec[4*i +: 4] = r_cnt[4*i +: 4] - 4'd1;
                    w_borrow        = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 16'h0000;
            r_pre   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pre   <= w_pre_nxt;
            r_done  <= w_done_nxt;
        end
    end

`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shadow <= 16'h0000;
        end else if (load) begin
            r_shadow <= w_ld;
        end
    end
`endif

    // Strobe priority: abort beats start; load always captures; in IDLE the zero test sees the value being loaded.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pre_nxt   = r_pre;
        w_done_nxt  = 1'b0;
        if (r_state == ST_IDLE) begin
            if (load) begin
                w_cnt_nxt = w_ld;
            end
            if (start && !abort) begin
                if (load ? w_ld_zero : w_cnt_zero) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_RUN;
                    w_pre_nxt   = '0;
                end
            end
        end else begin
            if (abort) begin
                w_state_nxt = ST_IDLE;
                if (load) begin
                    w_cnt_nxt = w_ld;
                end
            end else if (load) begin
                w_cnt_nxt = w_ld;
                w_pre_nxt = '0;
                if (w_ld_zero) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end else if (w_tick) begin
                w_pre_nxt = '0;
                w_cnt_nxt = w_dec;
                if (w_dec_zero) begin
                    w_done_nxt = 1'b1;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
                    if (r_shadow != 16'h0000) begin
                        w_cnt_nxt = r_shadow;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
`else
                    w_state_nxt = ST_IDLE;
`endif
                end
            end else begin
                w_pre_nxt = r_pre + PRE_ONE;
            end
        end
    end

    assign {BCD3, BCD2, BCD1, BCD0} = r_cnt;
    assign running = (r_state == ST_RUN);
    assign done    = r_done;

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed bench for bcd_countdown with TICK_DIV = 4; expected counts are hand-computed per step.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_bcd_countdown;

    logic       clock;
    logic       reset;
    logic       load;
    logic [3:0] LD0, LD1, LD2, LD3;
    logic       start;
    logic       abort;
    logic [3:0] BCD0, BCD1, BCD2, BCD3;
    logic       running;
    logic       done;

    int n_pass;
    int n_total;

    bcd_countdown #(
        .TICK_DIV(4),
        .PRE_W   (3)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .load   (load),
        .LD0    (LD0),
        .LD1    (LD1),
        .LD2    (LD2),
        .LD3    (LD3),
        .start  (start),
        .abort  (abort),
        .BCD0   (BCD0),
        .BCD1   (BCD1),
        .BCD2   (BCD2),
        .BCD3   (BCD3),
        .running(running),
        .done   (done)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] count();
        return {BCD3, BCD2, BCD1, BCD0};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // driver tasks
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        {LD3, LD2, LD1, LD0} = v;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b0;
        load    = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        {LD3, LD2, LD1, LD0} = 16'h0000;

        // reset state
        cyc();
        cyc();
        chk("rst_count", count(), 16'h0000);
        chk("rst_running", 16'(running), 16'h0);
        chk("rst_done", 16'(done), 16'h0);
        reset = 1'b1;
        cyc();

        // reset mid-count
        do_load(16'h0012);
        chk("t1_load", count(), 16'h0012);
        do_start();
        chk("t1_running", 16'(running), 16'h1);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk("t1_done_quiet", 16'(done), 16'h0);
        end
        chk("t1_count_before_rst", count(), 16'h0011);
        reset = 1'b0;
        #1;
        chk("t1_async_count", count(), 16'h0000);
        chk("t1_async_running", 16'(running), 16'h0);
        chk("t1_async_done", 16'(done), 16'h0);
        cyc();
        chk("t1_hold_done", 16'(done), 16'h0);
        reset = 1'b1;
        cyc();
        chk("t1_after_done", 16'(done), 16'h0);

        // borrow ripple
        do_load(16'h1000);
        do_start();
        for (int i = 1; i <= 4; i++) cyc();
        chk("t2_first_tick", count(), 16'h0999);
        for (int i = 1; i <= 3; i++) cyc();
        chk("t2_between", count(), 16'h0999);
        cyc();
        chk("t2_second_tick", count(), 16'h0998);
        chk("t2_running", 16'(running), 16'h1);
        do_abort();
        chk("t2_abort_running", 16'(running), 16'h0);
        chk("t2_abort_hold", count(), 16'h0998);

`ifndef BCD_COUNTDOWN_AUTORELOAD_EN
        // expiry
        do_load(16'h0003);
        do_start();
        for (int i = 1; i <= 12; i++) begin
            cyc();
            chk("t3_count", count(), 16'(3 - i / 4));
            chk("t3_done", 16'(done), 16'(i == 12));
            chk("t3_running", 16'(running), 16'(i != 12));
        end
        for (int i = 1; i <= 6; i++) begin
            cyc();
            chk("t3_stay_zero", count(), 16'h0000);
            chk("t3_done_off", 16'(done), 16'h0);
        end
`endif

        // zero start and clamp
        do_load(16'h0000);
        do_start();
        chk("t4_zero_done", 16'(done), 16'h1);
        chk("t4_zero_running", 16'(running), 16'h0);
        cyc();
        chk("t4_zero_done_off", 16'(done), 16'h0);
        chk("t4_zero_still_idle", 16'(running), 16'h0);
        do_load(16'hABCF);
        chk("t4_clamp", count(), 16'h9999);
        chk("t4_clamp_idle", 16'(running), 16'h0);

        // load + start with clamped zero check, and abort beating start
        {LD3, LD2, LD1, LD0} = 16'h000F;
        load  = 1'b1;
        start = 1'b1;
        cyc();
        load  = 1'b0;
        start = 1'b0;
        chk("t4_ldstart_count", count(), 16'h0009);
        chk("t4_ldstart_running", 16'(running), 16'h1);
        chk("t4_ldstart_done", 16'(done), 16'h0);
        do_abort();
        abort = 1'b1;
        start = 1'b1;
        cyc();
        abort = 1'b0;
        start = 1'b0;
        chk("t4_abort_prio", 16'(running), 16'h0);
        chk("t4_abort_prio_done", 16'(done), 16'h0);

        // abort and restart
        do_load(16'h0050);
        do_start();
        for (int i = 1; i <= 9; i++) cyc();
        chk("t5_before_abort", count(), 16'h0048);
        do_abort();
        chk("t5_abort_count", count(), 16'h0048);
        chk("t5_abort_running", 16'(running), 16'h0);
        chk("t5_abort_done", 16'(done), 16'h0);
        for (int i = 1; i <= 5; i++) cyc();
        chk("t5_idle_hold", count(), 16'h0048);
        do_start();
        chk("t5_restart_running", 16'(running), 16'h1);
        for (int i = 1; i <= 3; i++) cyc();
        chk("t5_pre_tick", count(), 16'h0048);
        cyc();
        chk("t5_resume_tick", count(), 16'h0047);

        // start while RUN is ignored (prescaler not cleared)
        do_start();
        for (int i = 1; i <= 3; i++) cyc();
        chk("t5_start_ignored", count(), 16'h0046);

        // loading 0000 while running expires immediately
        do_load(16'h0000);
        chk("t5_ld0_count", count(), 16'h0000);
        chk("t5_ld0_done", 16'(done), 16'h1);
        chk("t5_ld0_running", 16'(running), 16'h0);
        cyc();
        chk("t5_ld0_done_off", 16'(done), 16'h0);

`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
        // autoreload periodic timer
        do_load(16'h0002);
        do_start();
        for (int i = 1; i <= 16; i++) begin
            cyc();
            chk("t6_count", count(), ((i % 8) < 4) ? 16'h0002 : 16'h0001);
            chk("t6_done", 16'(done), 16'((i % 8) == 0));
            chk("t6_running", 16'(running), 16'h1);
        end
        do_abort();
        chk("t6_abort_running", 16'(running), 16'h0);
        for (int i = 1; i <= 8; i++) cyc();
        chk("t6_abort_hold", count(), 16'h0002);
        chk("t6_abort_done", 16'(done), 16'h0);
`endif

        // final report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
